// File: rtl/axi_rd_arbiter.sv
// Read-side AXI4 arbiter: grants one of dcache/uncache/icache, issues a single AR burst,
// collects the matching R beats into a shared line buffer and pulses the granted reload line.
module axi_rd_arbiter (
    input  logic         clk,
    input  logic         resetn,
    input  logic         ird_req,
    input  logic [31:0]  ird_addr,
    output logic         i_reload,
    output logic [511:0] icacheline_new,
    input  logic         drd_req,
    input  logic [31:0]  drd_addr,
    output logic         d_reload,
    output logic [255:0] dcacheline_new,
    input  logic         unrd_req,
    input  logic [31:0]  unrd_addr,
    output logic         un_reload,
    output logic [31:0]  unrd_data,
    output logic [3:0]   arid,
    output logic [31:0]  araddr,
    output logic [3:0]   arlen,
    output logic [2:0]   arsize,
    output logic [1:0]   arburst,
    output logic [1:0]   arlock,
    output logic [3:0]   arcache,
    output logic [2:0]   arprot,
    output logic         arvalid,
    input  logic         arready,
    input  logic [3:0]   rid,
    input  logic [31:0]  rdata,
    input  logic [1:0]   rresp,
    input  logic         rlast,
    input  logic         rvalid,
    output logic         rready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SRC_I = 2'd0,
        SRC_D = 2'd1,
        SRC_U = 2'd2
    } src_e;

    state_e         state_q, state_d;
    src_e           src_q, src_d;
    logic [3:0]     arid_q, arid_d;
    logic [31:0]    araddr_q, araddr_d;
    logic [3:0]     arlen_q, arlen_d;
    logic [3:0]     beat_q, beat_d;
    logic [511:0]   line_q, line_d;
    logic           arvalid_q, arvalid_d;
    logic           rready_q, rready_d;
    logic           i_reload_q, i_reload_d;
    logic           d_reload_q, d_reload_d;
    logic           un_reload_q, un_reload_d;
    logic           unused_inputs_s;

    // Low address bits are masked by line alignment and the response code is not acted upon.
    assign unused_inputs_s = ^{rresp, drd_addr[4:0], ird_addr[5:0]};

    // Next-state: arbitration, burst tracking, beat capture and registered handshake/pulse outputs.
    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        arid_d   = arid_q;
        araddr_d = araddr_q;
        arlen_d  = arlen_q;
        beat_d   = beat_q;
        line_d   = line_q;
        case (state_q)
            ST_IDLE: begin
                if (drd_req) begin
                    src_d    = SRC_D;
                    arid_d   = 4'd1;
                    araddr_d = {drd_addr[31:5], 5'b00000};
                    arlen_d  = 4'd7;
                    beat_d   = 4'd0;
                    state_d  = ST_AR;
                end else if (unrd_req) begin
                    src_d    = SRC_U;
                    arid_d   = 4'd2;
                    araddr_d = unrd_addr;
                    arlen_d  = 4'd0;
                    beat_d   = 4'd0;
                    state_d  = ST_AR;
                end else if (ird_req) begin
                    src_d    = SRC_I;
                    arid_d   = 4'd0;
                    araddr_d = {ird_addr[31:6], 6'b000000};
                    arlen_d  = 4'd15;
                    beat_d   = 4'd0;
                    state_d  = ST_AR;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_AR: begin
                if (arvalid_q && arready) begin
                    state_d = ST_R;
                end else begin
                    state_d = ST_AR;
                end
            end
            ST_R: begin
                // Beats tagged with another id belong to nobody here and are dropped.
                if (rvalid && (rid == arid_q)) begin
                    line_d[{beat_q, 5'b00000} +: 32] = rdata;
                    beat_d = beat_q + 4'd1;
                    if (rlast) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_R;
                    end
                end else begin
                    state_d = ST_R;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        arvalid_d   = (state_d == ST_AR);
        rready_d    = (state_d == ST_R);
        i_reload_d  = (state_d == ST_DONE) && (src_d == SRC_I);
        d_reload_d  = (state_d == ST_DONE) && (src_d == SRC_D);
        un_reload_d = (state_d == ST_DONE) && (src_d == SRC_U);
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            src_q       <= SRC_I;
            arid_q      <= 4'd0;
            araddr_q    <= 32'd0;
            arlen_q     <= 4'd0;
            beat_q      <= 4'd0;
            line_q      <= 512'd0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            i_reload_q  <= 1'b0;
            d_reload_q  <= 1'b0;
            un_reload_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            arid_q      <= arid_d;
            araddr_q    <= araddr_d;
            arlen_q     <= arlen_d;
            beat_q      <= beat_d;
            line_q      <= line_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            i_reload_q  <= i_reload_d;
            d_reload_q  <= d_reload_d;
            un_reload_q <= un_reload_d;
        end
    end

    assign arid           = arid_q;
    assign araddr         = araddr_q;
    assign arlen          = arlen_q;
    assign arsize         = 3'b010;
    assign arburst        = 2'b01;
    assign arlock         = 2'b00;
    assign arcache        = 4'b0000;
    assign arprot         = 3'b000;
    assign arvalid        = arvalid_q;
    assign rready         = rready_q;
    assign i_reload       = i_reload_q;
    assign d_reload       = d_reload_q;
    assign un_reload      = un_reload_q;
    assign icacheline_new = line_q;
    assign dcacheline_new = line_q[255:0];
    assign unrd_data      = line_q[31:0];

endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Read-side AXI4 arbiter and sequencer for the cached CPU top. It shares the single AXI read channel between three requesters: icache line refill (16 beats), dcache line refill (8 beats) and uncache single-word read. It grants one requester, issues the AR burst, assembles the R beats into a line buffer, and returns the data with a one-cycle reload pulse. It sits between the icache/dcache/uncache blocks and the AXI port, and the write-side controller runs alongside it.

## Interface
- No parameters; burst shapes are fixed by cache line sizes (icache 64 B, dcache 32 B).
- clk  in  1  core clock (aclk)
- resetn  in  1  asynchronous active-low reset
- ird_req / ird_addr  in  1 / 32  icache refill request (level) and miss address
- i_reload  out  1  one-cycle pulse: icacheline_new valid
- icacheline_new  out  512  assembled icache line
- drd_req / drd_addr  in  1 / 32  dcache refill request and address
- d_reload  out  1  pulse: dcacheline_new valid
- dcacheline_new  out  256  assembled dcache line
- unrd_req / unrd_addr  in  1 / 32  uncached word read request and address
- un_reload  out  1  pulse: unrd_data valid
- unrd_data  out  32  uncached read word
- arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid  out  4,32,4,3,2,2,4,3,1  AXI read address channel
- arready  in  1
- rid, rdata, rresp, rlast, rvalid  in  4,32,2,1,1  AXI read data channel
- rready  out  1

## Operation
- FSM states: IDLE, AR, R, DONE. Reset state is IDLE.
- IDLE:
  - Fixed priority grant: drd_req > unrd_req > ird_req.
  - On grant, latch the source, id, address and length, clear the beat index, and go to AR.
- Per-source AR fields:
  - dcache: arid=1, araddr={drd_addr[31:5],5'b0}, arlen=7.
  - uncache: arid=2, araddr=unrd_addr unmodified, arlen=0.
  - icache: arid=0, araddr={ird_addr[31:6],6'b0}, arlen=15.
  - Constant for all sources: arsize=3'b010, arburst=2'b01 (INCR), arlock=0, arcache=0, arprot=0.
- AR: arvalid=1, with all AR fields held stable until arready. On arvalid&&arready go to R.
- R:
  - rready=1.
  - A beat is accepted when rvalid && rid==latched id. rdata is written to buf[32k+31:32k], where k is the beat index, and k then increments.
  - Beats with a non-matching rid are dropped.
  - rresp is ignored.
  - An accepted beat with rlast=1 moves the FSM to DONE. rlast alone terminates the burst; k is not compared with arlen.
- DONE: pulse the reload line of the granted source only, for exactly one cycle, then go to IDLE.
- Outputs are continuous views of the line buffer: icacheline_new=buf[511:0], dcacheline_new=buf[255:0], unrd_data=buf[31:0]. The buffer holds its value until the next accepted beat.
- Requester contract: a requester holds req high until it sees its reload pulse, and must deassert req on the clock edge after that pulse. The arbiter performs no re-arbitration and no preemption while a transaction is active.
- Only one transaction is outstanding at a time; there is no AR/R overlap.

## Timing
- Reset values: arvalid=0, rready=0, all reload pulses=0, buf=0, araddr/arid/arlen=0, state=IDLE, beat index=0.
- Reset asserted mid-transaction aborts everything immediately and asynchronously, and no reload pulse is generated. Recovery of the AXI slave is outside this block's scope.
- arvalid is registered: it rises the cycle after a request is seen in IDLE and drops the cycle after the handshake.
- rready is high for every cycle spent in R and low in every other state.
- Minimum latency, from a req sampled high in IDLE to the reload pulse: 3 + arlen cycles, assuming arready=1 and rvalid on every cycle.
  - uncache: 3 cycles
  - dcache: 10 cycles
  - icache: 18 cycles
- After DONE there is exactly one IDLE cycle before the next grant, so back-to-back transactions are separated by DONE plus IDLE.
- Simultaneous requests are granted in priority order. A losing requester keeps its req high and is granted in the first IDLE cycle in which no higher-priority req is asserted. Sustained dcache traffic can starve icache; this is accepted behaviour.

## Test plan
- Uncache read alone: unrd_req=1 with addr 0xBFAF_8004, slave replies with rdata 0x1234_5678 and rlast → arid=2, araddr=0xBFAF_8004, arlen=0; un_reload pulses for 1 cycle exactly 3 cycles after the request; unrd_data=0x1234_5678.
- Icache refill, addr 0xBFC0_0124 → araddr=0xBFC0_0100, arlen=15. Beats 0..15 carry the values 0x100+k, so icacheline_new[32k+31:32k]=0x100+k. i_reload pulses once and d_reload/un_reload stay 0.
- Simultaneous ird_req, drd_req and unrd_req → grant order dcache, uncache, icache; arid sequence 1, 2, 0, each AR separated by DONE plus IDLE.
- Backpressure: arready held low for 5 cycles → arvalid and araddr stay stable; after the handshake, insert random rvalid gaps → dcacheline_new is still correct and latency grows by exactly the number of stall cycles.
- Stray beat: during a dcache burst inject rvalid with rid=3 → beat is ignored, beat index is unchanged and the line is intact.
- Reset asserted after the 4th beat of an icache burst → all outputs go to their reset values that cycle and no i_reload pulse appears; a fresh uncache read afterwards completes normally.
